// File: rtl/chaotic_pkg.sv
// Shared types and constants for the chaotic-equation iteration sequencer.
package chaotic_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } seq_state_e;

  // Iteration modes; the unused encoding 2'b11 behaves as single step
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_FREE   = 2'b10;

  // Burst length with zero promoted to one
  function automatic logic [31:0] eff_burst_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/chaotic_iter_sequencer.sv
// Iteration sequencer for an external chaotic-equation engine.
// Owns the (x,y,z) state buffer, issues it to the engine, feeds each result
// back as the next input and presents non-discarded results on a
// valid/ready output. Supports single step, burst of N and free run.
//
//   state | meaning
//   INIT  | one cycle after reset: copy seed inputs into the buffer
//   IDLE  | waiting for seed_load or a start edge
//   ISSUE | waiting for the engine to be free, then strobe eng_valid
//   WAIT  | engine computing; waiting for eng_out_valid
//   HOLD  | output word valid, waiting for out_ready
module chaotic_iter_sequencer
  import chaotic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic [CNT_WIDTH-1:0]  discard_n,
  input  logic                  seed_load,
  input  logic [DATA_WIDTH-1:0] x_seed,
  input  logic [DATA_WIDTH-1:0] y_seed,
  input  logic [DATA_WIDTH-1:0] z_seed,
  output logic                  eng_valid,
  output logic [DATA_WIDTH-1:0] eng_xn,
  output logic [DATA_WIDTH-1:0] eng_yn,
  output logic [DATA_WIDTH-1:0] eng_zn,
  input  logic                  eng_busy,
  input  logic                  eng_out_valid,
  input  logic [DATA_WIDTH-1:0] eng_xn1,
  input  logic [DATA_WIDTH-1:0] eng_yn1,
  input  logic [DATA_WIDTH-1:0] eng_zn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] xn1,
  output logic [DATA_WIDTH-1:0] yn1,
  output logic [DATA_WIDTH-1:0] zn1,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  iter_cnt,
  output logic                  spurious
);

  seq_state_e            state_q;
  logic [1:0]            mode_q;
  logic                  start_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [CNT_WIDTH-1:0]  iter_q;
  logic [DATA_WIDTH-1:0] buf_x_q, buf_y_q, buf_z_q;
  logic [DATA_WIDTH-1:0] out_x_q, out_y_q, out_z_q;
  logic                  eng_valid_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  spurious_q;

  logic                  start_edge;
  logic                  discard_hit;
  logic                  run_more;
  logic [CNT_WIDTH-1:0]  remaining_d;
  logic [CNT_WIDTH-1:0]  remaining_init;
  logic [CNT_WIDTH-1:0]  iter_d;

  // Derived control terms: start edge, discard test on the pre-increment
  // count, and whether the run continues after an output handshake.
  always_comb begin
    start_edge     = start & ~start_q;
    discard_hit    = (iter_q < discard_n);
    iter_d         = iter_q + CNT_WIDTH'(1);
    remaining_d    = remaining_q - CNT_WIDTH'(1);
    remaining_init = (burst_len == '0) ? CNT_WIDTH'(1) : burst_len;
    run_more       = 1'b0;
    case (mode_q)
      MODE_BURST: run_more = (remaining_d != '0);
      MODE_FREE:  run_more = ~stop;
      default:    run_more = 1'b0;
    endcase
  end

  // Sequencer FSM with state buffer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      mode_q      <= MODE_SINGLE;
      start_q     <= 1'b0;
      remaining_q <= '0;
      iter_q      <= '0;
      buf_x_q     <= '0;
      buf_y_q     <= '0;
      buf_z_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      eng_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      start_q     <= start;
      eng_valid_q <= 1'b0;
      case (state_q)
        INIT: begin
          buf_x_q <= x_seed;
          buf_y_q <= y_seed;
          buf_z_q <= z_seed;
          iter_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        IDLE: begin
          // seed_load has priority; a coincident start edge is dropped
          if (seed_load) begin
            buf_x_q    <= x_seed;
            buf_y_q    <= y_seed;
            buf_z_q    <= z_seed;
            iter_q     <= '0;
            spurious_q <= 1'b0;
          end else if (start_edge) begin
            mode_q      <= mode;
            remaining_q <= remaining_init;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!eng_busy) begin
            eng_valid_q <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (eng_out_valid) begin
            buf_x_q <= eng_xn1;
            buf_y_q <= eng_yn1;
            buf_z_q <= eng_zn1;
            iter_q  <= iter_d;
            if (discard_hit) begin
              // warm-up result: loop again unless free run was stopped
              if (mode_q == MODE_FREE && stop) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                state_q <= ISSUE;
              end
            end else begin
              out_x_q     <= eng_xn1;
              out_y_q     <= eng_yn1;
              out_z_q     <= eng_zn1;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (mode_q == MODE_BURST) begin
              remaining_q <= remaining_d;
            end
            if (run_more) begin
              // issue straight from the handshake when the engine is free,
              // so the next eng_valid follows the handshake by one cycle
              if (!eng_busy) begin
                eng_valid_q <= 1'b1;
                state_q     <= WAIT;
              end else begin
                state_q <= ISSUE;
              end
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // a result strobe outside WAIT is never consumed; flag it (this
      // takes precedence over a same-cycle clear by seed_load)
      if (eng_out_valid && state_q != WAIT) begin
        spurious_q <= 1'b1;
      end
    end
  end

  assign eng_valid = eng_valid_q;
  assign eng_xn    = buf_x_q;
  assign eng_yn    = buf_y_q;
  assign eng_zn    = buf_z_q;
  assign out_valid = out_valid_q;
  assign xn1       = out_x_q;
  assign yn1       = out_y_q;
  assign zn1       = out_z_q;
  assign busy      = busy_q;
  assign iter_cnt  = iter_q;
  assign spurious  = spurious_q;

endmodule
